// File: rtl/time_syn_pkg.sv
// Shared definitions for the time-sync link: preamble codes, frame length,
// frame-type and receiver state encodings.
package time_syn_pkg;

    localparam int          FRAME_LEN  = 8;
    localparam logic [7:0]  TS_PRE     = 8'h66;
    localparam logic [7:0]  STD_PRE    = 8'h88;
    localparam logic [7:0]  RETURN_PRE = 8'h55;

    typedef enum logic [1:0] {
        FT_TS     = 2'd0,
        FT_STD    = 2'd1,
        FT_RETURN = 2'd2,
        FT_NONE   = 2'd3
    } frame_type_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_HEAD = 2'd1,
        ST_BODY = 2'd2,
        ST_DROP = 2'd3
    } rx_state_t;

    function automatic frame_type_t classify_pre(
        input logic [7:0] code,
        input logic [7:0] ts_pre,
        input logic [7:0] std_pre,
        input logic [7:0] ret_pre
    );
        frame_type_t t;
        t = FT_NONE;
        if (code == ts_pre)       t = FT_TS;
        else if (code == std_pre) t = FT_STD;
        else if (code == ret_pre) t = FT_RETURN;
        return t;
    endfunction

endpackage

// File: rtl/time_syn_rx.sv
// Time-sync link receiver: parses fixed-length AXIS frames, classifies them by
// preamble and presents the carried time word plus local arrival time.
module time_syn_rx
    import time_syn_pkg::*;
#(
    parameter int          P_FRAME_LEN  = FRAME_LEN,
    parameter logic [7:0]  P_TS_PRE     = TS_PRE,
    parameter logic [7:0]  P_STD_PRE    = STD_PRE,
    parameter logic [7:0]  P_RETURN_PRE = RETURN_PRE
) (
    input  logic        i_clk,
    input  logic        i_rst_n,
    input  logic [63:0] i_local_time,
    input  logic        i_rx_axis_tvalid,
    input  logic [63:0] i_rx_axis_tdata,
    input  logic        i_rx_axis_tlast,
    input  logic [7:0]  i_rx_axis_tkeep,
    input  logic        i_rx_axis_tuser,
    output logic        o_rx_axis_tready,
    output logic        o_recv_ts_valid,
    output logic        o_recv_std_valid,
    output logic        o_recv_return_valid,
    output logic [63:0] o_recv_time,
    output logic [63:0] o_recv_arrive_time,
    output logic        o_frame_err,
    output logic [15:0] o_err_cnt
);

    localparam logic [7:0] LAST_BEAT = 8'(P_FRAME_LEN - 1);

    rx_state_t   r_state, w_state_nxt;
    frame_type_t r_type, w_type;
    logic        r_ready;
    logic [7:0]  r_beat_cnt;
    logic        r_bad;
    logic [63:0] r_time, r_arrive;

    logic        w_rx_en, w_beat_bad;
    logic        w_start, w_time_ld, w_commit, w_err;

    logic        r_ts_vld_p1, r_std_vld_p1, r_ret_vld_p1, r_err_p1;
    logic [63:0] r_recv_time_p1, r_arrive_time_p1;
    logic [15:0] r_err_cnt;

    assign w_rx_en    = i_rx_axis_tvalid & r_ready;
    assign w_beat_bad = i_rx_axis_tuser | (i_rx_axis_tkeep != 8'hff);
    assign w_type     = classify_pre(i_rx_axis_tdata[7:0], P_TS_PRE, P_STD_PRE, P_RETURN_PRE);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_ready <= 1'b1;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_start     = 1'b0;
        w_time_ld   = 1'b0;
        w_commit    = 1'b0;
        w_err       = 1'b0;
        case (r_state)
            ST_IDLE: w_state_nxt = ST_HEAD;
            ST_HEAD: begin
                if (w_rx_en) begin
                    if (i_rx_axis_tlast) begin
                        w_err = 1'b1;
                    end else if (w_type != FT_NONE) begin
                        w_start     = 1'b1;
                        w_state_nxt = ST_BODY;
                    end else begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_BODY: begin
                if (w_rx_en) begin
                    w_time_ld = (r_beat_cnt == 8'd1);
                    if (i_rx_axis_tlast) begin
                        w_state_nxt = ST_HEAD;
                        // Only a correctly terminated, clean frame is committed
                        if (r_beat_cnt == LAST_BEAT && !(r_bad | w_beat_bad))
                            w_commit = 1'b1;
                        else
                            w_err = 1'b1;
                    end else if (r_beat_cnt == LAST_BEAT) begin
                        w_err       = 1'b1;
                        w_state_nxt = ST_DROP;
                    end
                end
            end
            ST_DROP: begin
                if (w_rx_en && i_rx_axis_tlast)
                    w_state_nxt = ST_HEAD;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_beat_cnt <= 8'd0;
            r_bad      <= 1'b0;
        end else begin
            if (r_state == ST_IDLE)
                r_beat_cnt <= 8'd0;
            else if (w_rx_en)
                r_beat_cnt <= i_rx_axis_tlast ? 8'd0 : r_beat_cnt + 8'd1;

            if (w_start)
                r_bad <= w_beat_bad;
            else if (r_state == ST_BODY && w_rx_en)
                r_bad <= r_bad | w_beat_bad;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_start) begin
            r_type   <= w_type;
            r_arrive <= i_local_time;
        end
        if (w_time_ld)
            r_time <= i_rx_axis_tdata;
    end

    // Result stage: registered one cycle after the final-beat handshake
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_ts_vld_p1      <= 1'b0;
            r_std_vld_p1     <= 1'b0;
            r_ret_vld_p1     <= 1'b0;
            r_recv_time_p1   <= 64'd0;
            r_arrive_time_p1 <= 64'd0;
            r_err_p1         <= 1'b0;
            r_err_cnt        <= 16'd0;
        end else begin
            r_ts_vld_p1  <= w_commit && (r_type == FT_TS);
            r_std_vld_p1 <= w_commit && (r_type == FT_STD);
            r_ret_vld_p1 <= w_commit && (r_type == FT_RETURN);
            if (w_commit) begin
                r_recv_time_p1   <= r_time;
                r_arrive_time_p1 <= r_arrive;
            end
            r_err_p1 <= w_err;
            if (w_err && r_err_cnt != 16'hffff)
                r_err_cnt <= r_err_cnt + 16'd1;
        end
    end

    assign o_rx_axis_tready    = r_ready;
    assign o_recv_ts_valid     = r_ts_vld_p1;
    assign o_recv_std_valid    = r_std_vld_p1;
    assign o_recv_return_valid = r_ret_vld_p1;
    assign o_recv_time         = r_recv_time_p1;
    assign o_recv_arrive_time  = r_arrive_time_p1;
    assign o_frame_err         = r_err_p1;
    assign o_err_cnt           = r_err_cnt;

endmodule
